// File: rtl/softmax_row_stream.sv
// softmax_row_stream: streaming row-wise softmax approximation.
// Each row of INPUT_SHAPE_2 signed elements is buffered, converted to base-2
// exponentials relative to the row maximum (2^FRAC_BITS >> (max - x)), summed,
// and each exponential is then divided by the sum with a bit-serial restoring
// divider to give an unsigned OUT_WIDTH-bit probability. Rows are tagged with
// a head index and a row index that walk through MATRIX_NUM x INPUT_SHAPE_1.
//
// Ports:
//   clk_p        - clock, rising edge
//   rst_n        - asynchronous active-low reset
//   in_data      - signed row element
//   in_valid_n   - active-low input valid
//   in_ready     - element can be accepted (only while loading a row)
//   out_data     - unsigned softmax value
//   out_valid_n  - active-low output valid
//   out_ready    - downstream accept
//   out_last     - final element of a row
//   out_head     - head index of the current output row
//   out_row      - row index within the head
module softmax_row_stream #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned MATRIX_NUM    = 12,
  parameter int unsigned INPUT_SHAPE_1 = 128,
  parameter int unsigned INPUT_SHAPE_2 = 128,
  parameter int unsigned FRAC_BITS     = 8,
  parameter int unsigned OUT_WIDTH     = 8,
  localparam int unsigned HeadW = (MATRIX_NUM > 1) ? $clog2(MATRIX_NUM) : 1,
  localparam int unsigned RowW  = (INPUT_SHAPE_1 > 1) ? $clog2(INPUT_SHAPE_1) : 1
) (
  input  logic                  clk_p,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid_n,
  output logic                  in_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_valid_n,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [HeadW-1:0]      out_head,
  output logic [RowW-1:0]       out_row
);

  localparam int unsigned IdxW    = (INPUT_SHAPE_2 > 1) ? $clog2(INPUT_SHAPE_2) : 1;
  localparam int unsigned ExpW    = FRAC_BITS + 1;
  localparam int unsigned SumW    = FRAC_BITS + 1 + $clog2(INPUT_SHAPE_2);
  localparam int unsigned TrialW  = SumW + 1;
  localparam int unsigned BufW    = (DATA_WIDTH > ExpW) ? DATA_WIDTH : ExpW;
  localparam int unsigned DiffW   = DATA_WIDTH + 1;
  localparam int unsigned DivCntW = $clog2(OUT_WIDTH + 1);

  localparam logic [ExpW-1:0]    ExpOne  = ExpW'(1) << FRAC_BITS;
  localparam logic [IdxW-1:0]    IdxLast = IdxW'(INPUT_SHAPE_2 - 1);
  localparam logic [DivCntW-1:0] DivLast = DivCntW'(OUT_WIDTH);

  typedef enum logic [2:0] {StIdle, StLoad, StExp, StDiv, StOut} state_e;

  state_e                        state_q, state_d;
  logic [IdxW-1:0]               idx_q, idx_d;
  logic signed [DATA_WIDTH-1:0]  max_q, max_d;
  logic [SumW-1:0]               sum_q, sum_d;
  logic [DivCntW-1:0]            div_cnt_q, div_cnt_d;
  logic [SumW-1:0]               rem_q, rem_d;
  logic [OUT_WIDTH:0]            quo_q, quo_d;
  logic [OUT_WIDTH-1:0]          out_data_q, out_data_d;
  logic [HeadW-1:0]              head_q, head_d;
  logic [RowW-1:0]               row_q, row_d;

  // Row buffer: holds raw elements during load, exponentials afterwards.
  logic [BufW-1:0]               buf_q [INPUT_SHAPE_2];
  logic                          buf_we;
  logic [BufW-1:0]               buf_wdata;

  logic [BufW-1:0]               rd;
  logic signed [DATA_WIDTH-1:0]  elem;
  logic signed [DATA_WIDTH-1:0]  in_s;
  logic [DiffW-1:0]              diff;
  logic [ExpW-1:0]               exp_val;
  logic [ExpW-1:0]               e_cur;
  logic [TrialW-1:0]             trial;
  logic                          ge;
  logic [SumW-1:0]               rem_sub;
  logic [OUT_WIDTH:0]            quo_next;
  logic                          in_fire;
  logic                          out_fire;

  assign in_ready    = (state_q == StLoad);
  assign out_valid_n = (state_q != StOut);
  assign out_last    = (state_q == StOut) && (idx_q == IdxLast);
  assign out_data    = out_data_q;
  assign out_head    = head_q;
  assign out_row     = row_q;

  assign in_fire  = in_ready && !in_valid_n;
  assign out_fire = (state_q == StOut) && out_ready;

  assign rd    = buf_q[idx_q];
  assign elem  = rd[DATA_WIDTH-1:0];
  assign in_s  = in_data;
  assign e_cur = rd[ExpW-1:0];

  // max >= every element of the row, so the sign-extended difference is non-negative.
  assign diff    = {max_q[DATA_WIDTH-1], max_q} - {elem[DATA_WIDTH-1], elem};
  assign exp_val = (diff <= DiffW'(FRAC_BITS)) ? (ExpOne >> diff) : '0;

  // Restoring divide of (e << OUT_WIDTH) by sum. Since e <= sum the quotient fits
  // in OUT_WIDTH+1 bits, so the first step compares e itself and each later step
  // shifts the remainder left by one.
  assign trial    = (div_cnt_q == '0) ? TrialW'(e_cur) : {rem_q, 1'b0};
  assign ge       = (trial >= {1'b0, sum_q});
  assign rem_sub  = trial[SumW-1:0] - sum_q;
  assign quo_next = {quo_q[OUT_WIDTH-1:0], ge};

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    max_d      = max_q;
    sum_d      = sum_q;
    div_cnt_d  = div_cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    out_data_d = out_data_q;
    head_d     = head_q;
    row_d      = row_q;
    buf_we     = 1'b0;
    buf_wdata  = '0;

    unique case (state_q)
      StIdle: begin
        state_d = StLoad;
      end
      StLoad: begin
        if (in_fire) begin
          buf_we    = 1'b1;
          buf_wdata = BufW'(in_data);
          if ((idx_q == '0) || (in_s > max_q)) begin
            max_d = in_s;
          end
          if (idx_q == IdxLast) begin
            idx_d   = '0;
            state_d = StExp;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StExp: begin
        buf_we    = 1'b1;
        buf_wdata = BufW'(exp_val);
        sum_d     = sum_q + SumW'(exp_val);
        if (idx_q == IdxLast) begin
          idx_d     = '0;
          div_cnt_d = '0;
          state_d   = StDiv;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDiv: begin
        rem_d = ge ? rem_sub : trial[SumW-1:0];
        quo_d = quo_next;
        if (div_cnt_q == DivLast) begin
          div_cnt_d  = '0;
          out_data_d = quo_next[OUT_WIDTH] ? '1 : quo_next[OUT_WIDTH-1:0];
          state_d    = StOut;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      StOut: begin
        if (out_fire) begin
          if (idx_q != IdxLast) begin
            idx_d     = idx_q + 1'b1;
            div_cnt_d = '0;
            state_d   = StDiv;
          end else begin
            idx_d   = '0;
            max_d   = '0;
            sum_d   = '0;
            state_d = StLoad;
            if (row_q == RowW'(INPUT_SHAPE_1 - 1)) begin
              row_d  = '0;
              head_d = (head_q == HeadW'(MATRIX_NUM - 1)) ? '0 : head_q + 1'b1;
            end else begin
              row_d = row_q + 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      max_q      <= '0;
      sum_q      <= '0;
      div_cnt_q  <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      out_data_q <= '0;
      head_q     <= '0;
      row_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      max_q      <= max_d;
      sum_q      <= sum_d;
      div_cnt_q  <= div_cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      out_data_q <= out_data_d;
      head_q     <= head_d;
      row_q      <= row_d;
    end
  end

  // Buffer contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk_p) begin
    if (buf_we) begin
      buf_q[idx_q] <= buf_wdata;
    end
  end

endmodule

// File: tb/tb_softmax_row_stream.sv
module tb_softmax_row_stream;

  localparam int N  = 4;
  localparam int R  = 2;
  localparam int M  = 2;
  localparam int DW = 8;
  localparam int FB = 8;
  localparam int OW = 8;

  logic         clk_p = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   in_data = '0;
  logic         in_valid_n = 1'b1;
  logic         in_ready;
  logic [7:0]   out_data;
  logic         out_valid_n;
  logic         out_ready = 1'b1;
  logic         out_last;
  logic [0:0]   out_head;
  logic [0:0]   out_row;

  softmax_row_stream #(
    .DATA_WIDTH   (DW),
    .MATRIX_NUM   (M),
    .INPUT_SHAPE_1(R),
    .INPUT_SHAPE_2(N),
    .FRAC_BITS    (FB),
    .OUT_WIDTH    (OW)
  ) dut (
    .clk_p      (clk_p),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid_n (in_valid_n),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid_n(out_valid_n),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .out_head   (out_head),
    .out_row    (out_row)
  );

  always #5 clk_p = ~clk_p;

  typedef struct {
    int data;
    int last;
    int head;
    int row;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  int   exp_head = 0;
  int   exp_row = 0;
  int   cyc = 0;
  int   last_out_cyc = 0;

  always @(posedge clk_p) cyc++;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Softmax model straight from the arithmetic definition.
  task automatic model_row(input int row[N], output int q[N], output int sum);
    int mx;
    int e[N];
    mx = row[0];
    for (int k = 1; k < N; k++) if (row[k] > mx) mx = row[k];
    sum = 0;
    for (int k = 0; k < N; k++) begin
      int d;
      d = mx - row[k];
      e[k] = (d <= FB) ? ((1 << FB) >> d) : 0;
      sum += e[k];
    end
    for (int k = 0; k < N; k++) begin
      q[k] = (e[k] * (1 << OW)) / sum;
      if (q[k] > (1 << OW) - 1) q[k] = (1 << OW) - 1;
    end
  endtask

  task automatic push_elem(input int x, output int edge_cyc);
    int t;
    t = 0;
    @(negedge clk_p);
    while (!in_ready && t < 3000) begin
      @(negedge clk_p);
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got in_ready=0 after %0d cycles, expected 1", t);
    end
    in_data    = x[7:0];
    in_valid_n = 1'b0;
    @(posedge clk_p);
    #1;
    edge_cyc   = cyc;
    in_valid_n = 1'b1;
  endtask

  task automatic push_row(input int row[N], output int first_cyc);
    int q[N];
    int s;
    int c;
    model_row(row, q, s);
    for (int k = 0; k < N; k++) begin
      exp_t e;
      e.data = q[k];
      e.last = (k == N - 1) ? 1 : 0;
      e.head = exp_head;
      e.row  = exp_row;
      exp_q.push_back(e);
    end
    if (exp_row == R - 1) begin
      exp_row  = 0;
      exp_head = (exp_head == M - 1) ? 0 : exp_head + 1;
    end else begin
      exp_row = exp_row + 1;
    end
    first_cyc = 0;
    for (int k = 0; k < N; k++) begin
      push_elem(row[k], c);
      if (k == 0) first_cyc = c;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(posedge clk_p);
      t++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d outputs pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Compare every output transfer against the model queue.
  always @(negedge clk_p) begin
    if (rst_n && !out_valid_n && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got out_data=%0d, expected no output", out_data);
      end else begin
        cur = exp_q.pop_front();
        check("out_data", int'(out_data), cur.data);
        check("out_last", int'(out_last), cur.last);
        check("out_head", int'(out_head), cur.head);
        check("out_row", int'(out_row), cur.row);
        check("in_ready_in_out", int'(in_ready), 0);
        if (cur.last != 0) last_out_cyc = cyc + 1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r[N];
    int q[N];
    int s;
    int fc;
    int t;
    int dummy;

    // Reset state
    #1;
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid_n", int'(out_valid_n), 1);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_out_head", int'(out_head), 0);
    check("rst_out_row", int'(out_row), 0);
    repeat (3) @(negedge clk_p);
    rst_n = 1'b1;

    // Hand-computed values pinning the model
    r = '{3, 2, 1, 0};
    model_row(r, q, s);
    check("model_sum_3210", s, 480);
    check("model_q0_3210", q[0], 136);
    check("model_q3_3210", q[3], 17);
    r = '{10, 0, 0, 0};
    model_row(r, q, s);
    check("model_sat", q[0], 255);
    check("model_zero", q[1], 0);
    r = '{-128, 127, -128, -128};
    model_row(r, q, s);
    check("model_signed_max", q[1], 255);
    check("model_signed_min", q[0], 0);
    r = '{5, 5, 5, 5};
    model_row(r, q, s);
    check("model_equal", q[2], 64);

    // Row 1: equal elements, latency with out_ready held high
    r = '{5, 5, 5, 5};
    push_row(r, fc);
    drain();
    check("row_latency", last_out_cyc - fc + 1, N + N + N * (OW + 2));

    // Row 2: with a 10-cycle output stall on the first element
    r = '{3, 2, 1, 0};
    push_row(r, fc);
    out_ready = 1'b0;
    t = 0;
    while (out_valid_n && t < 200) begin
      @(posedge clk_p);
      #1;
      t++;
    end
    check("stall_reach_out", int'(out_valid_n), 0);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk_p);
      #1;
      check("stall_valid_n", int'(out_valid_n), 0);
      check("stall_data", int'(out_data), 136);
      check("stall_last", int'(out_last), 0);
      check("stall_in_ready", int'(in_ready), 0);
      check("stall_pending", exp_q.size(), N);
    end
    out_ready = 1'b1;
    drain();

    // Rows 3-5: saturation, signed extremes, head/row wrap
    r = '{10, 0, 0, 0};
    push_row(r, fc);
    r = '{-128, 127, -128, -128};
    push_row(r, fc);
    r = '{1, 2, 3, 4};
    push_row(r, fc);
    drain();

    // Reset after two loaded elements discards the partial row
    push_elem(7, dummy);
    push_elem(9, dummy);
    @(negedge clk_p);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", int'(in_ready), 0);
    check("mid_rst_out_valid_n", int'(out_valid_n), 1);
    check("mid_rst_out_data", int'(out_data), 0);
    check("mid_rst_out_head", int'(out_head), 0);
    check("mid_rst_out_row", int'(out_row), 0);
    exp_head = 0;
    exp_row  = 0;
    repeat (2) @(negedge clk_p);
    rst_n = 1'b1;
    r = '{3, 2, 1, 0};
    push_row(r, fc);
    drain();

    repeat (5) @(posedge clk_p);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/softmax_row_stream.md
SOFTMAX_ROW_STREAM -- requirements
Module: softmax_row_stream

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning signed input element width.
REQ-002 The block SHALL have parameter MATRIX_NUM, default 12, meaning number of heads (matrices) time-multiplexed through the block.
REQ-003 The block SHALL have parameter INPUT_SHAPE_1, default 128, meaning rows per matrix.
REQ-004 The block SHALL have parameter INPUT_SHAPE_2, default 128, meaning elements per row (softmax length).
REQ-005 The block SHALL have parameter FRAC_BITS, default 8, meaning exponent fixed-point fraction bits.
REQ-006 The block SHALL have parameter OUT_WIDTH, default 8, meaning unsigned probability output width.
REQ-007 The block SHALL have port clk_p, input, 1 bit: the single clock; all logic is rising-edge.
REQ-008 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-009 The block SHALL have port in_data, input, DATA_WIDTH bits: signed row element.
REQ-010 The block SHALL have port in_valid_n, input, 1 bit: active-low input valid.
REQ-011 The block SHALL have port in_ready, output, 1 bit: high when an element can be accepted.
REQ-012 The block SHALL have port out_data, output, OUT_WIDTH bits: unsigned softmax value.
REQ-013 The block SHALL have port out_valid_n, output, 1 bit: active-low output valid.
REQ-014 The block SHALL have port out_ready, input, 1 bit: downstream accept.
REQ-015 The block SHALL have port out_last, output, 1 bit: high with the final element of a row.
REQ-016 The block SHALL have port out_head, output, clog2(MATRIX_NUM) bits: head index of the current output row.
REQ-017 The block SHALL have port out_row, output, clog2(INPUT_SHAPE_1) bits: row index within the head.

Function
REQ-018 A transfer SHALL occur on a rising edge where valid_n==0 and ready==1; any other cycle transfers nothing.
REQ-019 FSM states SHALL be IDLE, LOAD, EXP, DIV, OUT; IDLE->LOAD on the first cycle after reset.
REQ-020 LOAD: in_ready=1; each transfer stores the element in a INPUT_SHAPE_2-deep buffer and updates the running signed max; after the INPUT_SHAPE_2-th transfer -> EXP.
REQ-021 in_ready SHALL be 0 in every state other than LOAD.
REQ-022 EXP: one element per cycle, d=max-x_i (unsigned, DATA_WIDTH+1 bits); e_i=2^FRAC_BITS>>d if d<=FRAC_BITS, else 0; e_i overwrites buffer entry; sum accumulates in FRAC_BITS+1+clog2(INPUT_SHAPE_2) bits without overflow; INPUT_SHAPE_2 cycles then -> DIV with index 0.
REQ-023 DIV: sequential restoring divide q=floor((e_i<<OUT_WIDTH)/sum), exactly OUT_WIDTH+1 cycles, then -> OUT.
REQ-024 q SHALL saturate to 2^OUT_WIDTH-1 when the quotient exceeds it.
REQ-025 OUT: out_valid_n=0, out_data=q; out_data, out_last, out_head, out_row SHALL stay stable until transfer.
REQ-026 On OUT transfer: if index<INPUT_SHAPE_2-1, increment index -> DIV; else -> LOAD, clear max and sum.
REQ-027 out_last SHALL be 1 only in OUT for index INPUT_SHAPE_2-1.
REQ-028 At row end out_row SHALL increment; at INPUT_SHAPE_1-1 it wraps to 0 and out_head increments, wrapping from MATRIX_NUM-1 to 0.
REQ-029 out_valid_n SHALL be 1 in every state other than OUT.
REQ-030 Minimum row latency SHALL be INPUT_SHAPE_2 (LOAD) + INPUT_SHAPE_2 (EXP) + INPUT_SHAPE_2*(OUT_WIDTH+2) cycles with out_ready held 1.
REQ-031 in_valid_n toggling mid-row SHALL only stall LOAD; partial rows are held indefinitely.

Reset
REQ-032 rst_n low SHALL asynchronously force state IDLE, in_ready=0, out_valid_n=1, out_data=0, out_last=0, out_head=0, out_row=0, and clear max, sum, index, element count.
REQ-033 Reset asserted mid-operation SHALL discard the partial row; buffer contents need no clearing.

Verification (INPUT_SHAPE_2=4, INPUT_SHAPE_1=2, MATRIX_NUM=2, DATA_WIDTH=8, FRAC_BITS=8, OUT_WIDTH=8)
REQ-034 Row {5,5,5,5}, out_ready=1 -> outputs 64,64,64,64; out_last on 4th; out_head=0, out_row=0.
REQ-035 Row {3,2,1,0} -> sum 480; outputs 136,68,34,17.
REQ-036 Row {10,0,0,0} -> e={256,0,0,0}; outputs 255 (saturated),0,0,0.
REQ-037 Row {-128,127,-128,-128} -> outputs 0,255,0,0; signed max handled.
REQ-038 out_ready=0 for 10 cycles during OUT -> out_data/out_valid_n stable, no index advance, in_ready=0.
REQ-039 Four rows back-to-back -> (head,row) = (0,0),(0,1),(1,0),(1,1), then wraps to (0,0); rst_n pulsed low after 2 LOAD transfers -> next 4 inputs form a fresh row with correct outputs.
